// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - iterative signed 32-bit multiply/divide sequencer
module multdiv_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [4:0]  r_count;
    // Shared accumulator: multiply keeps {partial product, multiplier},
    // divide keeps {partial remainder, dividend/quotient}.
    logic [63:0] r_acc;
    logic [31:0] r_mag_b;      // multiplicand or divisor magnitude
    logic        r_neg;        // result sign
    logic        r_b_zero;
    logic        r_div_ovf;

    logic        w_start;
    logic        w_last;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_acc;
    logic [63:0] w_product;
    logic        w_mul_exc;
    logic [32:0] w_rem_shift;
    logic [32:0] w_div_diff;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;
    logic [31:0] w_div_result;

    assign w_start = ctrl_MULT | ctrl_DIV;
    assign w_last  = (r_count == 5'd31);
    assign w_mag_a = data_operandA[31] ? -data_operandA : data_operandA;
    assign w_mag_b = data_operandB[31] ? -data_operandB : data_operandB;

    // Shift/add step: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_mag_b} : 33'd0);
    assign w_mul_acc = {w_mul_sum, r_acc[31:1]};
    assign w_product = r_neg ? -w_mul_acc : w_mul_acc;
    assign w_mul_exc = !((&w_product[63:31]) || (~|w_product[63:31]));

    // Restoring step: bring in the next dividend bit, subtract the divisor,
    // keep the difference only when it did not go negative.
    assign w_rem_shift = {r_acc[63:32], r_acc[31]};
    assign w_div_diff  = w_rem_shift - {1'b0, r_mag_b};
    assign w_rem_next  = w_div_diff[32] ? w_rem_shift[31:0] : w_div_diff[31:0];
    assign w_quo_next  = {r_acc[30:0], ~w_div_diff[32]};
    assign w_div_result = r_b_zero ? 32'd0 : (r_neg ? -w_quo_next : w_quo_next);

    assign data_resultRDY = (r_state == S_DONE);
    assign busy           = (r_state == S_MUL) || (r_state == S_DIV);

    // State register
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Next state: any start restarts (multiply wins), else count out to DONE
    always_comb begin
        w_next_state = r_state;
        if (ctrl_MULT) begin
            w_next_state = S_MUL;
        end else if (ctrl_DIV) begin
            w_next_state = S_DIV;
        end else begin
            case (r_state)
                S_MUL, S_DIV: if (w_last) w_next_state = S_DONE;
                S_DONE:       w_next_state = S_IDLE;
                default:      w_next_state = r_state;
            endcase
        end
    end

    // Datapath: latch operands on start, iterate, publish result entering DONE
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count        <= 5'd0;
            r_acc          <= 64'd0;
            r_mag_b        <= 32'd0;
            r_neg          <= 1'b0;
            r_b_zero       <= 1'b0;
            r_div_ovf      <= 1'b0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
        end else if (w_start) begin
            r_count   <= 5'd0;
            r_acc     <= {32'd0, ctrl_MULT ? w_mag_b : w_mag_a};
            r_mag_b   <= ctrl_MULT ? w_mag_a : w_mag_b;
            r_neg     <= data_operandA[31] ^ data_operandB[31];
            r_b_zero  <= (data_operandB == 32'd0);
            r_div_ovf <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
        end else if (r_state == S_MUL) begin
            r_acc <= w_mul_acc;
            if (w_last) begin
                data_result    <= w_product[31:0];
                data_exception <= w_mul_exc;
            end else begin
                r_count <= r_count + 5'd1;
            end
        end else if (r_state == S_DIV) begin
            r_acc <= {w_rem_next, w_quo_next};
            if (w_last) begin
                data_result    <= w_div_result;
                data_exception <= r_b_zero | r_div_ovf;
            end else begin
                r_count <= r_count + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb/tb_multdiv_sequencer.sv - self-checking bench for multdiv_sequencer
module tb_multdiv_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = 32'd0;
    logic [31:0] data_operandB = 32'd0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_checks = 0;
    int n_fails  = 0;

    multdiv_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: {exception, result}
    function automatic logic [32:0] expect_op(input logic is_mul, input logic [31:0] a, input logic [31:0] b);
        longint p;
        logic [31:0] lo;
        int sa;
        int sb;
        int q;
        if (is_mul) begin
            p  = longint'($signed(a)) * longint'($signed(b));
            lo = p[31:0];
            return {(p != longint'($signed(lo))), lo};
        end
        if (b == 32'd0) return {1'b1, 32'd0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
        sa = a;
        sb = b;
        q  = sa / sb;
        return {1'b0, 32'(q)};
    endfunction

    // Behavioural model: an operation finishes 32 edges after its start
    // unless restarted or reset; results persist until the next completion.
    logic        m_busy = 1'b0;
    logic        m_rdy  = 1'b0;
    logic        m_exc  = 1'b0;
    logic [31:0] m_res  = 32'd0;
    logic [32:0] m_pend = 33'd0;
    int          m_left = 0;

    always @(posedge clock) begin
        if (reset) begin
            m_busy = 1'b0; m_rdy = 1'b0; m_exc = 1'b0; m_res = 32'd0; m_left = 0;
        end else if (ctrl_MULT || ctrl_DIV) begin
            m_pend = expect_op(ctrl_MULT, data_operandA, data_operandB);
            m_busy = 1'b1; m_rdy = 1'b0; m_left = 32;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0; m_rdy = 1'b1;
                m_res = m_pend[31:0]; m_exc = m_pend[32];
            end
        end else begin
            m_rdy = 1'b0;
        end
        #1;
        check("model busy", {32'd0, busy}, {32'd0, m_busy});
        check("model rdy", {32'd0, data_resultRDY}, {32'd0, m_rdy});
        check("model result", {1'b0, data_result}, {1'b0, m_res});
        check("model exception", {32'd0, data_exception}, {32'd0, m_exc});
    end

    function automatic logic [31:0] rand_operand();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20)) - 32'd10;
            4: return {{16{r[15]}}, r[15:0]};
            default: return r;
        endcase
    endfunction

    task automatic run_directed(input string name, input logic m, input logic d,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp_res, input logic exp_exc);
        @(negedge clock);
        ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
        @(negedge clock);
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = $urandom; data_operandB = $urandom;
        check({name, " busy after start"}, {32'd0, busy}, 33'd1);
        repeat (31) @(negedge clock);
        check({name, " no rdy at E31"}, {32'd0, data_resultRDY}, 33'd0);
        @(negedge clock);
        check({name, " rdy at E32"}, {32'd0, data_resultRDY}, 33'd1);
        check({name, " idle at E32"}, {32'd0, busy}, 33'd0);
        check({name, " result"}, {1'b0, data_result}, {1'b0, exp_res});
        check({name, " exception"}, {32'd0, data_exception}, {32'd0, exp_exc});
        @(negedge clock);
        check({name, " rdy one cycle"}, {32'd0, data_resultRDY}, 33'd0);
    endtask

    initial begin
        check("pin mul", expect_op(1'b1, 32'd7, 32'hFFFF_FFFD), {1'b0, 32'hFFFF_FFEB});
        check("pin mul ovf", expect_op(1'b1, 32'h0001_0000, 32'h0001_0000), {1'b1, 32'd0});
        check("pin div", expect_op(1'b0, 32'hFFFF_FFF9, 32'd2), {1'b0, 32'hFFFF_FFFD});

        repeat (3) @(negedge clock);
        check("reset busy", {32'd0, busy}, 33'd0);
        check("reset rdy", {32'd0, data_resultRDY}, 33'd0);
        check("reset result", {1'b0, data_result}, 33'd0);
        check("reset exception", {32'd0, data_exception}, 33'd0);
        reset = 1'b0;

        run_directed("mul", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        run_directed("mul ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1);
        run_directed("div", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        run_directed("div zero", 1'b0, 1'b1, 32'd5, 32'd0, 32'd0, 1'b1);
        run_directed("div ovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_directed("dual", 1'b1, 1'b1, 32'd6, 32'd4, 32'd24, 1'b0);

        // Reset at E10 of a multiply
        @(negedge clock);
        ctrl_MULT = 1'b1; data_operandA = 32'd9; data_operandB = 32'd9;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("reset mid busy", {32'd0, busy}, 33'd0);
        check("reset mid result", {1'b0, data_result}, 33'd0);
        for (int i = 11; i <= 40; i++) begin
            @(negedge clock);
            if (data_resultRDY !== 1'b0) check("reset no rdy", {32'd0, data_resultRDY}, 33'd0);
        end
        check("reset still idle", {32'd0, busy}, 33'd0);

        // Abort: multiply at E0, divide 100/7 at E5
        @(negedge clock);
        ctrl_MULT = 1'b1; data_operandA = 32'd3; data_operandB = 32'd5;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        repeat (4) @(negedge clock);
        ctrl_DIV = 1'b1; data_operandA = 32'd100; data_operandB = 32'd7;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        repeat (27) @(negedge clock);
        check("abort no rdy E32", {32'd0, data_resultRDY}, 33'd0);
        check("abort busy E32", {32'd0, busy}, 33'd1);
        repeat (4) @(negedge clock);
        check("abort no rdy E36", {32'd0, data_resultRDY}, 33'd0);
        @(negedge clock);
        check("abort rdy E37", {32'd0, data_resultRDY}, 33'd1);
        check("abort result", {1'b0, data_result}, {1'b0, 32'd14});
        check("abort exception", {32'd0, data_exception}, 33'd0);

        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 6000; i++) begin
            @(negedge clock);
            reset         = ($urandom_range(0, 299) == 0);
            ctrl_MULT     = ($urandom_range(0, 79) == 0);
            ctrl_DIV      = ($urandom_range(0, 79) == 0);
            data_operandA = rand_operand();
            data_operandB = rand_operand();
        end
        @(negedge clock);
        reset = 1'b0; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        repeat (40) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
